requant_pipe: RTL and testbench

- Fully pipelined, per-channel requantization unit. The next generation of the single-shot multiply-by-quantized-multiplier FSM.
- Accepts one int32 accumulator per cycle, tagged with a channel index. Looks up that channel's multiplier and shift.
- Computes RoundingDivideByPOT(SaturatingRoundingDoublingHighMul(x << ls, M), rs), then adds the output zero point and clamps to the activation range.
- Sits between the MAC array accumulators and the activation writeback.

---
 rtl/requant_pipe.sv | 172 +++++++++++++++++
 tb/tb_requant_pipe.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/requant_pipe.sv
// Six-stage per-channel requantizer: int32 accumulator -> scaled, rounded, offset and
// clamped OUT_W-bit activation, one result per cycle.
module requant_pipe #(
    parameter int CH      = 16,
    parameter int OUT_W   = 8,
    parameter int SHIFT_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_we,
    input  logic [$clog2(CH)-1:0] cfg_ch,
    input  logic [31:0]           cfg_mult,
    input  logic [SHIFT_W-1:0]    cfg_shift,
    input  logic [31:0]           out_zp,
    input  logic [OUT_W-1:0]      act_min,
    input  logic [OUT_W-1:0]      act_max,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_x,
    input  logic [$clog2(CH)-1:0] in_ch,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_W-1:0]      out_data,
    output logic                  busy
);
    localparam logic [31:0] MULT_RESET = 32'h4000_0000;
    localparam logic [31:0] MIN_Q31    = 32'h8000_0000;

    logic [31:0]        r_mult  [CH];
    logic [SHIFT_W-1:0] r_shift [CH];

    // Table writes land at the edge; the S0 read in the same cycle sees the old entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CH; i++) begin
                r_mult[i]  <= MULT_RESET;
                r_shift[i] <= '0;
            end
        end else if (cfg_we) begin
            r_mult[cfg_ch]  <= cfg_mult;
            r_shift[cfg_ch] <= cfg_shift;
        end
    end

    // Handshake: a word moves in on in_valid && in_ready and out on out_valid && out_ready.
    // The whole pipe advances together only while the output slot is empty or draining.
    logic w_adv;
    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

    logic r_v0, r_v1, r_v2, r_v3, r_v4, r_v5;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v0 <= 1'b0;
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
            r_v4 <= 1'b0;
            r_v5 <= 1'b0;
        end else if (w_adv) begin
            r_v0 <= in_valid;
            r_v1 <= r_v0;
            r_v2 <= r_v1;
            r_v3 <= r_v2;
            r_v4 <= r_v3;
            r_v5 <= r_v4;
        end
    end

    assign out_valid = r_v5;
    assign busy      = r_v0 | r_v1 | r_v2 | r_v3 | r_v4 | r_v5;

    logic [31:0]        r_x0, r_m0;
    logic [SHIFT_W-1:0] r_sh0;
    logic [31:0]        r_a1, r_m1;
    logic [4:0]         r_rs1, r_rs2, r_rs3;
    logic signed [63:0] r_ab2;
    logic               r_ovf2;
    logic [31:0]        r_h3, r_q4;
    logic [OUT_W-1:0]   r_out;

    // S1: split the signed shift into a left part and a right part, each capped at 31.
    logic signed [31:0] w_sh_ext, w_neg;
    logic [4:0]         w_ls, w_rs;
    logic [31:0]        w_a;
    assign w_sh_ext = {{(32-SHIFT_W){r_sh0[SHIFT_W-1]}}, r_sh0};
    assign w_neg    = -w_sh_ext;
    assign w_ls     = (w_sh_ext <= 32'sd0) ? 5'd0 : ((w_sh_ext > 32'sd31) ? 5'd31 : w_sh_ext[4:0]);
    assign w_rs     = (w_sh_ext >= 32'sd0) ? 5'd0 : ((w_neg > 32'sd31) ? 5'd31 : w_neg[4:0]);
    assign w_a      = r_x0 << w_ls;

    // S2: full signed product of the shifted value and the Q31 multiplier.
    logic signed [63:0] w_a64, w_m64, w_ab;
    assign w_a64 = {{32{r_a1[31]}}, r_a1};
    assign w_m64 = {{32{r_m1[31]}}, r_m1};
    assign w_ab  = w_a64 * w_m64;

    // S3: doubling high-mul; floor shift plus a correction gives truncation toward zero.
    logic signed [63:0] w_nudge, w_sum, w_shr, w_tdiv;
    logic [31:0]        w_h;
    assign w_nudge = r_ab2[63] ? (64'sd1 - 64'sd1073741824) : 64'sd1073741824;
    assign w_sum   = r_ab2 + w_nudge;
    assign w_shr   = w_sum >>> 31;
    assign w_tdiv  = w_shr + ((w_sum[63] && (w_sum[30:0] != 31'd0)) ? 64'sd1 : 64'sd0);
    assign w_h     = r_ovf2 ? 32'h7FFF_FFFF : w_tdiv[31:0];

    // S4: rounding divide by 2^rs, ties away from zero.
    logic [31:0] w_mask, w_rem, w_thr, w_hsr, w_q;
    assign w_mask = (32'd1 << r_rs3) - 32'd1;
    assign w_rem  = r_h3 & w_mask;
    assign w_thr  = (w_mask >> 1) + {31'd0, r_h3[31]};
    assign w_hsr  = $signed(r_h3) >>> r_rs3;
    assign w_q    = w_hsr + {31'd0, (w_rem > w_thr)};

    // S5: 33-bit zero-point add so the clamp sees the true sum.
    logic signed [32:0] w_s, w_lo, w_hi;
    logic [OUT_W-1:0]   w_clamp;
    assign w_s  = {r_q4[31], r_q4} + {out_zp[31], out_zp};
    assign w_lo = {{(33-OUT_W){act_min[OUT_W-1]}}, act_min};
    assign w_hi = {{(33-OUT_W){act_max[OUT_W-1]}}, act_max};

    always_comb begin
        w_clamp = w_s[OUT_W-1:0];
        if (w_s < w_lo) begin
            w_clamp = act_min;
        end else if (w_s > w_hi) begin
            w_clamp = act_max;
        end
    end

    logic w_unused;
    assign w_unused = ^{w_tdiv[63:32], w_s[32:OUT_W]};

    always_ff @(posedge clk) begin
        if (w_adv) begin
            if (in_valid) begin
                r_x0  <= in_x;
                r_m0  <= r_mult[in_ch];
                r_sh0 <= r_shift[in_ch];
            end
            if (r_v0) begin
                r_a1  <= w_a;
                r_m1  <= r_m0;
                r_rs1 <= w_rs;
            end
            if (r_v1) begin
                r_ab2  <= w_ab;
                r_ovf2 <= (r_a1 == MIN_Q31) && (r_m1 == MIN_Q31);
                r_rs2  <= r_rs1;
            end
            if (r_v2) begin
                r_h3  <= w_h;
                r_rs3 <= r_rs2;
            end
            if (r_v3) begin
                r_q4 <= w_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out <= '0;
        end else if (w_adv && r_v4) begin
            r_out <= w_clamp;
        end
    end

    assign out_data = r_out;

endmodule

// File: tb/tb_requant_pipe.sv
// Directed bench for requant_pipe: latency, rounding, saturation, clamp, channel mixing,
// back-pressure, same-cycle table write and mid-flight reset.
module tb_requant_pipe;
    localparam int CH      = 16;
    localparam int OUT_W   = 8;
    localparam int SHIFT_W = 6;

    logic               clk       = 1'b0;
    logic               rst       = 1'b1;
    logic               cfg_we    = 1'b0;
    logic [3:0]         cfg_ch    = '0;
    logic [31:0]        cfg_mult  = '0;
    logic [SHIFT_W-1:0] cfg_shift = '0;
    logic [31:0]        out_zp    = '0;
    logic [OUT_W-1:0]   act_min   = 8'h80;
    logic [OUT_W-1:0]   act_max   = 8'h7F;
    logic               in_valid  = 1'b0;
    logic [31:0]        in_x      = '0;
    logic [3:0]         in_ch     = '0;
    logic               out_ready = 1'b1;
    logic               in_ready, out_valid, busy;
    logic [OUT_W-1:0]   out_data;

    requant_pipe #(.CH(CH), .OUT_W(OUT_W), .SHIFT_W(SHIFT_W)) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mult(cfg_mult), .cfg_shift(cfg_shift),
        .out_zp(out_zp), .act_min(act_min), .act_max(act_max),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_ch(in_ch),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int               tests_run = 0;
    int               fails     = 0;
    logic [OUT_W-1:0] exp_q[$];
    bit               mon_en    = 1'b0;
    bit               bp_en     = 1'b0;
    int               bp_idx    = 0;
    logic [3:0]       bp_pat    = 4'b1001;
    int               cyc       = 0;
    int               pop_cnt   = 0;
    int               first_cyc = 0;
    int               last_cyc  = 0;
    int               stall_cnt = 0;
    logic             prev_stall = 1'b0;
    logic [OUT_W-1:0] prev_data  = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Downstream ready pattern, changed just after each rising edge.
    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (bp_en) begin
            out_ready = bp_pat[bp_idx];
            bp_idx    = (bp_idx + 1) % 4;
        end else begin
            out_ready = 1'b1;
        end
    end

    // Scoreboard: every transfer out must match the head of exp_q.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bp_en) begin
                if (prev_stall) begin
                    check("hold_valid", out_valid, 1);
                    check("hold_data", out_data, prev_data);
                end
                check("in_ready_rule", in_ready, !(out_valid && !out_ready));
            end
            if (out_valid && !out_ready) stall_cnt++;
            if (out_valid && out_ready) begin
                check("out_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    check("out_data", out_data, exp_q.pop_front());
                    pop_cnt++;
                    if (pop_cnt == 1) first_cyc = cyc;
                    last_cyc = cyc;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic cfg(input logic [3:0] ch, input logic [31:0] m, input logic [SHIFT_W-1:0] sh);
        @(negedge clk);
        cfg_we = 1'b1; cfg_ch = ch; cfg_mult = m; cfg_shift = sh;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic send(input logic [31:0] x, input logic [3:0] ch, input logic [OUT_W-1:0] exp);
        int guard = 0;
        @(negedge clk);
        in_valid = 1'b1; in_x = x; in_ch = ch;
        exp_q.push_back(exp);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("send_accept", guard < 100, 1);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int guard = 0;
        while ((exp_q.size() != 0 || busy) && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_empty"}, exp_q.size(), 0);
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish expected finish by 100000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [OUT_W-1:0] t4_exp [8];
        t4_exp = '{8'd1, 8'd4, 8'd2, 8'd8, 8'd3, 8'd12, 8'd4, 8'd16};

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_data", out_data, 0);
        check("rst_in_ready", in_ready, 1);
        mon_en = 1'b1;

        // T1: default entry 0.5, x=100 -> 50, six cycles after accept
        @(negedge clk);
        in_valid = 1'b1; in_x = 32'd100; in_ch = 4'd0;
        exp_q.push_back(8'd50);
        check("t1_ready", in_ready, 1);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            check($sformatf("t1_lat%0d", k), out_valid, (k == 6));
        end
        check("t1_data", out_data, 8'd50);
        drain("t1");

        // T2: right shift by one with rounding; negative truncation toward zero
        cfg(4'd1, 32'h4000_0000, 6'h3F);
        send(32'd101, 4'd1, 8'd26);
        send(32'd100, 4'd1, 8'd25);
        send(32'hFFFF_FFFD, 4'd0, 8'hFF);
        idle();
        drain("t2");

        // T3: saturating high-mul then clamp high; big negative zero point clamps low
        cfg(4'd2, 32'h8000_0000, 6'h00);
        send(32'h8000_0000, 4'd2, 8'h7F);
        idle();
        drain("t3a");
        out_zp = 32'hFFFF_FF38;
        send(32'd20, 4'd0, 8'h80);
        idle();
        drain("t3b");
        out_zp = 32'd0;

        // T4: left shift, then back-to-back alternating channels
        cfg(4'd3, 32'h4000_0000, 6'd2);
        send(32'd10, 4'd3, 8'd20);
        idle();
        drain("t4a");
        pop_cnt = 0;
        for (int i = 1; i <= 8; i++) begin
            send(i, (i % 2 == 1) ? 4'd0 : 4'd3, t4_exp[i-1]);
        end
        idle();
        drain("t4b");
        check("t4_count", pop_cnt, 8);
        check("t4_span", last_cyc - first_cyc, 7);

        // T5: 12 words under out_ready pattern 1,0,0,1
        bp_idx    = 0;
        stall_cnt = 0;
        pop_cnt   = 0;
        bp_en     = 1'b1;
        for (int i = 0; i < 12; i++) begin
            send(2 * (i + 1), 4'd0, 8'(i + 1));
        end
        idle();
        drain("t5");
        bp_en = 1'b0;
        check("t5_count", pop_cnt, 12);
        check("t5_stalled", stall_cnt != 0, 1);

        // T6a: table write in the accept cycle uses the old entry; next word sees the new one
        @(negedge clk);
        cfg_we = 1'b1; cfg_ch = 4'd0; cfg_mult = 32'h2000_0000; cfg_shift = '0;
        in_valid = 1'b1; in_x = 32'd100; in_ch = 4'd0;
        exp_q.push_back(8'd50);
        check("t6_ready", in_ready, 1);
        @(negedge clk);
        cfg_we = 1'b0;
        in_x   = 32'd100;
        exp_q.push_back(8'd25);
        @(negedge clk);
        in_valid = 1'b0;
        drain("t6a");

        // T6b: reset with four words in flight discards them and restores the table
        mon_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_x = 32'd7 + i; in_ch = 4'd0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("t6_inflight_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_rst_out_valid", out_valid, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_in_ready", in_ready, 1);
        mon_en = 1'b1;
        repeat (12) @(negedge clk);
        check("t6_post_busy", busy, 0);
        send(32'd100, 4'd0, 8'd50);
        idle();
        drain("t6b");

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
